// File: rtl/pic_bus_master.sv
// CPU-side initiator for an 8259-style PIC bus: turns valid/ready requests into timed
// CS_n/RD_n/WR_n/A0 cycles and runs the two-pulse INTA sequence to fetch the vector byte.
module pic_bus_master #(
  parameter int unsigned SETUP_CYC = 1,
  parameter int unsigned PULSE_CYC = 3,
  parameter int unsigned HOLD_CYC  = 1,
  parameter int unsigned INTA_GAP  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rd,
  input  logic       req_a0,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  input  logic       int_req,
  input  logic       ack_en,
  output logic       vec_valid,
  output logic [7:0] vec_data,
  output logic       busy,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       inta_n,
  output logic       a0,
  output logic [7:0] d_out,
  output logic       d_oe,
  input  logic [7:0] d_in
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_INTA1, S_GAP, S_INTA2, S_IHOLD
  } state_t;

  localparam logic [7:0] SETUP_LD = 8'(SETUP_CYC - 1);
  localparam logic [7:0] PULSE_LD = 8'(PULSE_CYC - 1);
  localparam logic [7:0] HOLD_LD  = 8'(HOLD_CYC - 1);
  localparam logic [7:0] GAP_LD   = 8'(INTA_GAP - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       rd_q, rd_d;
  logic       inta_pending, accept, last;
  logic       frame_d;

  assign inta_pending = int_req && ack_en;
  assign req_ready    = (state_q == S_IDLE) && !rst && !inta_pending;
  assign busy         = (state_q != S_IDLE);
  assign accept       = req_valid && req_ready;
  assign last         = (cnt_q == 8'd0);

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    cnt_d   = last ? cnt_q : cnt_q - 8'd1;
    rd_d    = accept ? req_rd : rd_q;
    case (state_q)
      S_IDLE: begin
        if (inta_pending) begin
          state_d = S_INTA1;
          cnt_d   = PULSE_LD;
        end else if (req_valid) begin
          state_d = S_SETUP;
          cnt_d   = SETUP_LD;
        end
      end
      S_SETUP:  if (last) begin state_d = S_STROBE; cnt_d = PULSE_LD; end
      S_STROBE: if (last) begin state_d = S_HOLD;   cnt_d = HOLD_LD;  end
      S_HOLD:   if (last) state_d = S_IDLE;
      S_INTA1:  if (last) begin state_d = S_GAP;    cnt_d = GAP_LD;   end
      S_GAP:    if (last) begin state_d = S_INTA2;  cnt_d = PULSE_LD; end
      S_INTA2:  if (last) begin state_d = S_IHOLD;  cnt_d = HOLD_LD;  end
      S_IHOLD:  if (last) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Strobes are registered from the next state so they line up exactly with the state register.
  assign frame_d = (state_d == S_SETUP) || (state_d == S_STROBE) || (state_d == S_HOLD);

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 8'd0;
      rd_q      <= 1'b0;
      cs_n      <= 1'b1;
      rd_n      <= 1'b1;
      wr_n      <= 1'b1;
      inta_n    <= 1'b1;
      a0        <= 1'b0;
      d_out     <= 8'd0;
      d_oe      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'd0;
      vec_valid <= 1'b0;
      vec_data  <= 8'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_q      <= rd_d;
      cs_n      <= !frame_d;
      rd_n      <= !((state_d == S_STROBE) && rd_d);
      wr_n      <= !((state_d == S_STROBE) && !rd_d);
      inta_n    <= !((state_d == S_INTA1) || (state_d == S_INTA2));
      d_oe      <= frame_d && !rd_d;
      if (accept) begin
        a0    <= req_a0;
        d_out <= req_wdata;
      end
      rsp_valid <= (state_q == S_STROBE) && last && rd_q;
      if ((state_q == S_STROBE) && last && rd_q) rsp_rdata <= d_in;
      vec_valid <= (state_q == S_INTA2) && last;
      if ((state_q == S_INTA2) && last) vec_data <= d_in;
    end
  end

endmodule
